// File: rtl/deserializer_1to64_sr.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_1to64_sr
// Description : Serial-to-parallel deserializer. It hunts for a 16-bit sync
//               pattern and then captures one MSB-first WIDTH-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer_1to64_sr #(
    parameter int          WIDTH        = 64,
    parameter logic [15:0] SYNC_PATTERN = 16'hA55A,
    parameter int          HUNT_LIMIT   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
    output logic [15:0]      frame_cnt,
    output logic             sync_err
);

    localparam int BCW = $clog2(WIDTH);
    localparam int HCW = (HUNT_LIMIT > 1) ? $clog2(HUNT_LIMIT) : 1;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    // The top bit of the window and of the shift register always shifts out
    // unused, so only the bits that feed the next value are stored.
    logic [14:0]        window_q,     window_d;
    logic [WIDTH-2:0]   shift_q,      shift_d;
    logic [BCW-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [HCW-1:0]     hunt_cnt_q,   hunt_cnt_d;
    logic [WIDTH-1:0]   data_out_q,   data_out_d;
    logic               data_valid_q, data_valid_d;
    logic [15:0]        frame_cnt_q,  frame_cnt_d;
    logic               sync_err_q,   sync_err_d;

    logic [15:0]        window_next;
    logic [WIDTH-1:0]   word_next;

    assign window_next = {window_q, serial_in};
    assign word_next   = {shift_q, serial_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            window_q     <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            hunt_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            hunt_cnt_q   <= hunt_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        hunt_cnt_d   = hunt_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        sync_err_d   = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                ST_HUNT: begin
                    window_d = window_next[14:0];
                    // A match wins over a timeout that lands on the same bit.
                    if (window_next == SYNC_PATTERN) begin
                        state_d    = ST_CAPTURE;
                        bit_cnt_d  = '0;
                        hunt_cnt_d = '0;
                    end else if (hunt_cnt_q == HCW'(HUNT_LIMIT - 1)) begin
                        sync_err_d = 1'b1;
                        hunt_cnt_d = '0;
                    end else begin
                        hunt_cnt_d = hunt_cnt_q + HCW'(1);
                    end
                end
                ST_CAPTURE: begin
                    shift_d   = word_next[WIDTH-2:0];
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                        data_out_d   = word_next;
                        data_valid_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        state_d      = ST_HUNT;
                        window_d     = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = (state_q == ST_CAPTURE);
    assign frame_cnt  = frame_cnt_q;
    assign sync_err   = sync_err_q;

endmodule
`default_nettype wire
